simple_mac_rx: RTL and testbench

SIMPLE_MAC_RX -- requirements
Module: simple_mac_rx

---
 rtl/mac_pkg.sv | 38 +++
 rtl/mac_crc32.sv | 24 ++
 rtl/simple_mac_rx.sv | 148 ++++++++++++++
 tb/tb_simple_mac_rx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg -- shared MAC state enum, Ethernet constants and CRC-32 helpers.
// Used by simple_mac_rx and mac_crc32; the nibble CRC update is shared with the TX MAC.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DRAIN,
        ST_DROP
    } rx_state_e;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
    localparam int unsigned ETH_MIN_LEN   = 64;
    localparam int unsigned ETH_MAX_LEN   = 1518;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // The CRC register shifts LSB-first, so it works with bit-reversed constants.
    localparam logic [31:0] CRC32_POLY_REFL    = bitrev32(CRC32_POLY);
    localparam logic [31:0] CRC32_RESIDUE_REFL = bitrev32(CRC32_RESIDUE);

    function automatic logic [31:0] crc32_nibble(input logic [31:0] crc,
                                                 input logic [3:0]  nib);
        logic [31:0] c;
        c = crc ^ {28'd0, nib};
        for (int i = 0; i < 4; i++)
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/mac_crc32.sv
// mac_crc32 -- nibble-serial reflected CRC-32, init all-ones, no final inversion.
// Ports: clk/rst, clr_i (reload init), en_i (absorb nib_i), crc_o (raw register).
module mac_crc32
    import mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [3:0]  nib_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        crc_q <= '1;
        else if (clr_i) crc_q <= '1;
        else if (en_i)  crc_q <= crc32_nibble(crc_q, nib_i);
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/simple_mac_rx.sv
// simple_mac_rx -- MII receive MAC: preamble/SFD strip, FCS strip, CRC/length check.
// Ports: eth_rxclk/rst, eth_rxdv/eth_rxer/eth_rxd in; rx_data/valid/sop/eop/err out.
// Build option: define MAC_RX_FILTER_EN to drop frames not for OWN_MAC or broadcast.
module simple_mac_rx
    import mac_pkg::*;
#(
    parameter logic [47:0] OWN_MAC = 48'h0200_0000_0001
) (
    input  logic       eth_rxclk,
    input  logic       rst,
    input  logic       eth_rxdv,
    input  logic       eth_rxer,
    input  logic [3:0] eth_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_err
);

`ifdef MAC_RX_FILTER_EN
    localparam logic FILTER_EN = 1'b1;
`else
    localparam logic FILTER_EN = 1'b0;
`endif

    rx_state_e   state_q;
    logic [3:0]  lo_q;
    logic        half_q;
    logic [10:0] cnt_q;
    logic [7:0]  dl_q [6];
    logic        rxer_q;
    logic [1:0]  ph_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        rx_sop_q;
    logic        rx_eop_q;
    logic        rx_err_q;

    logic [31:0] crc_w;
    logic [7:0]  byte_w;
    logic [47:0] dest_w;
    logic        dest_bad;
    logic        len_bad;
    logic        err_w;

    assign byte_w = {eth_rxd, lo_q};
    assign dest_w = {dl_q[4], dl_q[3], dl_q[2], dl_q[1], dl_q[0], byte_w};

    assign dest_bad = FILTER_EN && (dest_w != OWN_MAC) && (dest_w != BCAST_MAC);

    assign len_bad = (cnt_q < 11'(ETH_MIN_LEN)) || (cnt_q > 11'(ETH_MAX_LEN));

    // half_q still set in DRAIN means the frame ended on a dangling nibble.
    assign err_w = (crc_w != CRC32_RESIDUE_REFL) | rxer_q | half_q | len_bad;

    mac_crc32 u_crc (
        .clk   (eth_rxclk),
        .rst   (rst),
        .clr_i (state_q == ST_PREAMBLE),
        .en_i  ((state_q == ST_DATA) && eth_rxdv),
        .nib_i (eth_rxd),
        .crc_o (crc_w)
    );

    always_ff @(posedge eth_rxclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_DROP;
            lo_q       <= '0;
            half_q     <= 1'b0;
            cnt_q      <= '0;
            dl_q       <= '{default: '0};
            rxer_q     <= 1'b0;
            ph_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (eth_rxdv)
                        state_q <= (eth_rxd == 4'h5) ? ST_PREAMBLE : ST_DROP;
                end
                ST_PREAMBLE: begin
                    half_q <= 1'b0;
                    cnt_q  <= '0;
                    rxer_q <= 1'b0;
                    if (!eth_rxdv)            state_q <= ST_IDLE;
                    else if (eth_rxd == 4'hD) state_q <= ST_DATA;
                    else if (eth_rxd != 4'h5) state_q <= ST_DROP;
                end
                ST_DATA: begin
                    if (eth_rxer) rxer_q <= 1'b1;
                    if (!eth_rxdv) begin
                        ph_q    <= '0;
                        state_q <= (cnt_q < 11'd6) ? ST_IDLE : ST_DRAIN;
                    end else if (!half_q) begin
                        lo_q   <= eth_rxd;
                        half_q <= 1'b1;
                    end else begin
                        half_q <= 1'b0;
                        if (cnt_q != '1) cnt_q <= cnt_q + 11'd1;
                        for (int i = 5; i > 0; i--) dl_q[i] <= dl_q[i-1];
                        dl_q[0] <= byte_w;
                        // Six-byte delay keeps the trailing FCS out of the stream.
                        if (cnt_q >= 11'd6) begin
                            rx_data_q  <= dl_q[5];
                            rx_valid_q <= 1'b1;
                            rx_sop_q   <= (cnt_q == 11'd6);
                        end
                        if ((cnt_q == 11'd5) && dest_bad) state_q <= ST_DROP;
                    end
                end
                ST_DRAIN: begin
                    ph_q <= ph_q + 2'd1;
                    if (ph_q == 2'd0) begin
                        rx_data_q  <= dl_q[5];
                        rx_valid_q <= 1'b1;
                        rx_sop_q   <= (cnt_q == 11'd6);
                    end else if (ph_q == 2'd2) begin
                        rx_data_q  <= dl_q[4];
                        rx_valid_q <= 1'b1;
                        rx_eop_q   <= 1'b1;
                        rx_err_q   <= err_w;
                        state_q    <= eth_rxdv ? ST_DROP : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!eth_rxdv) state_q <= ST_IDLE;
                end
                default: state_q <= ST_DROP;
            endcase
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_sop   = rx_sop_q;
    assign rx_eop   = rx_eop_q;
    assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_simple_mac_rx.sv
// tb_simple_mac_rx -- directed frame tests for simple_mac_rx.
// Each task drives MII nibbles and checks the captured byte stream.
module tb_simple_mac_rx;

    typedef logic [7:0] bq_t[$];

    localparam logic [47:0] OWN     = 48'h0200_0000_0001;
    localparam logic [47:0] FOREIGN = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_MAC = 48'h0200_0000_0002;
`ifdef MAC_RX_FILTER_EN
    localparam int EXP_FOREIGN = 0;
`else
    localparam int EXP_FOREIGN = 60;
`endif

    logic       clk;
    logic       rst;
    logic       eth_rxdv;
    logic       eth_rxer;
    logic [3:0] eth_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sop;
    logic       rx_eop;
    logic       rx_err;

    int checks;
    int errors;

    logic [7:0] mon_data[$];
    logic       mon_sop[$];
    logic       mon_eop[$];
    logic       mon_err[$];
    int         viol;
    logic       prev_v;

    int   a_n, a_sop_n, a_first_sop, a_eop_n, a_eop_idx, a_bad;
    logic a_err;

    logic [11:0] rst_snap;
    int          rel_base;

    simple_mac_rx #(.OWN_MAC(OWN)) dut (
        .eth_rxclk (clk),
        .rst       (rst),
        .eth_rxdv  (eth_rxdv),
        .eth_rxer  (eth_rxer),
        .eth_rxd   (eth_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_sop    (rx_sop),
        .rx_eop    (rx_eop),
        .rx_err    (rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        viol   = 0;
        prev_v = 1'b0;
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            mon_data.push_back(rx_data);
            mon_sop.push_back(rx_sop);
            mon_eop.push_back(rx_eop);
            mon_err.push_back(rx_err);
        end
        if (rx_valid && prev_v) viol++;
        prev_v = rx_valid;
    end

    function automatic logic [31:0] fcs_of(input bq_t f);
        logic [31:0] c;
        c = '1;
        foreach (f[i]) begin
            c = c ^ {24'd0, f[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input int n, output bq_t f);
        logic [31:0] c;
        f = {};
        for (int i = 5; i >= 0; i--) f.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(SRC_MAC[i*8 +: 8]);
        f.push_back(8'h08);
        f.push_back(8'h00);
        for (int i = 14; i < n - 4; i++) f.push_back(8'(i * 7 + 3));
        c = fcs_of(f);
        for (int i = 0; i < 4; i++) f.push_back(c[i*8 +: 8]);
    endtask

    task automatic drv(input logic dv, input logic [3:0] d, input logic er);
        @(posedge clk);
        #1;
        eth_rxdv = dv;
        eth_rxd  = d;
        eth_rxer = er;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 4'h0, 1'b0);
    endtask

    task automatic send_frame(input bq_t f, input bit extra,
                              input int rxer_byte, input int rst_byte);
        repeat (15) drv(1'b1, 4'h5, 1'b0);
        drv(1'b1, 4'hD, 1'b0);
        foreach (f[i]) begin
            drv(1'b1, f[i][3:0], (i + 1) == rxer_byte);
            if (rst_byte > 0 && (i + 1) == rst_byte) begin
                rst = 1'b1;
                #1;
                rst_snap = {rx_data, rx_valid, rx_sop, rx_eop, rx_err};
            end
            if (rst_byte > 0 && (i + 1) == rst_byte + 2) begin
                rst      = 1'b0;
                rel_base = mon_data.size();
            end
            drv(1'b1, f[i][7:4], 1'b0);
        end
        if (extra) drv(1'b1, 4'hA, 1'b0);
        drv(1'b0, 4'h0, 1'b0);
    endtask

    task automatic analyze(input int base, input bq_t exp);
        a_n = mon_data.size() - base;
        a_sop_n = 0; a_first_sop = -1; a_eop_n = 0; a_eop_idx = -1;
        a_err = 1'b0; a_bad = 0;
        for (int i = 0; i < a_n; i++) begin
            if (mon_sop[base+i]) begin
                a_sop_n++;
                if (a_first_sop < 0) a_first_sop = i;
            end
            if (mon_eop[base+i]) begin
                a_eop_n++;
                a_eop_idx = i;
                a_err = a_err | mon_err[base+i];
            end
            if (i < exp.size() && mon_data[base+i] !== exp[i]) a_bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; eth_rxdv = 1'b0; eth_rxer = 1'b0; eth_rxd = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", rx_data); end
        checks++; if (rx_sop !== 1'b0) begin errors++; $display("FAIL rst_sop got %b exp 0", rx_sop); end
        checks++; if (rx_eop !== 1'b0) begin errors++; $display("FAIL rst_eop got %b exp 0", rx_eop); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", rx_err); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_good();
        bq_t f; int base; int v0;
        build_frame(OWN, 64, f);
        base = mon_data.size(); v0 = viol;
        send_frame(f, 1'b0, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 60) begin errors++; $display("FAIL good_n got %0d exp 60", a_n); end
        checks++; if (a_first_sop !== 0) begin errors++; $display("FAIL good_sop_idx got %0d exp 0", a_first_sop); end
        checks++; if (a_sop_n !== 1) begin errors++; $display("FAIL good_sop_n got %0d exp 1", a_sop_n); end
        checks++; if (a_eop_n !== 1) begin errors++; $display("FAIL good_eop_n got %0d exp 1", a_eop_n); end
        checks++; if (a_eop_idx !== 59) begin errors++; $display("FAIL good_eop_idx got %0d exp 59", a_eop_idx); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL good_err got %b exp 0", a_err); end
        checks++; if (a_bad !== 0) begin errors++; $display("FAIL good_data got %0d bad exp 0", a_bad); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL good_spacing got %0d exp %0d", viol, v0); end
    endtask

    task automatic test_bitflip();
        bq_t f; int base;
        build_frame(OWN, 64, f);
        f[30] = f[30] ^ 8'h10;
        base = mon_data.size();
        send_frame(f, 1'b0, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 60) begin errors++; $display("FAIL flip_n got %0d exp 60", a_n); end
        checks++; if (a_eop_idx !== 59) begin errors++; $display("FAIL flip_eop_idx got %0d exp 59", a_eop_idx); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL flip_err got %b exp 1", a_err); end
    endtask

    task automatic test_filter();
        bq_t f; int base;
        build_frame(FOREIGN, 64, f);
        base = mon_data.size();
        send_frame(f, 1'b0, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== EXP_FOREIGN) begin errors++; $display("FAIL foreign_n got %0d exp %0d", a_n, EXP_FOREIGN); end
        build_frame(BCAST, 64, f);
        base = mon_data.size();
        send_frame(f, 1'b0, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 60) begin errors++; $display("FAIL bcast_n got %0d exp 60", a_n); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL bcast_err got %b exp 0", a_err); end
        checks++; if (a_bad !== 0) begin errors++; $display("FAIL bcast_data got %0d bad exp 0", a_bad); end
    endtask

    task automatic test_rx_errors();
        bq_t f; int base;
        build_frame(OWN, 64, f);
        base = mon_data.size();
        send_frame(f, 1'b0, 20, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 60) begin errors++; $display("FAIL rxer_n got %0d exp 60", a_n); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL rxer_err got %b exp 1", a_err); end
        base = mon_data.size();
        send_frame(f, 1'b1, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 60) begin errors++; $display("FAIL odd_n got %0d exp 60", a_n); end
        checks++; if (a_eop_n !== 1) begin errors++; $display("FAIL odd_eop_n got %0d exp 1", a_eop_n); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL odd_err got %b exp 1", a_err); end
    endtask

    task automatic test_lengths();
        bq_t f; int base;
        build_frame(OWN, 63, f);
        base = mon_data.size();
        send_frame(f, 1'b0, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 59) begin errors++; $display("FAIL runt_n got %0d exp 59", a_n); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL runt_err got %b exp 1", a_err); end
        f = f[0:4];
        base = mon_data.size();
        send_frame(f, 1'b0, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 0) begin errors++; $display("FAIL tiny_n got %0d exp 0", a_n); end
        build_frame(OWN, 1518, f);
        base = mon_data.size();
        send_frame(f, 1'b0, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 1514) begin errors++; $display("FAIL max_n got %0d exp 1514", a_n); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL max_err got %b exp 0", a_err); end
        build_frame(OWN, 1519, f);
        base = mon_data.size();
        send_frame(f, 1'b0, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 1515) begin errors++; $display("FAIL over_n got %0d exp 1515", a_n); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL over_err got %b exp 1", a_err); end
    endtask

    task automatic test_bad_preamble();
        bq_t f; int base;
        base = mon_data.size();
        drv(1'b1, 4'h5, 1'b0);
        drv(1'b1, 4'h5, 1'b0);
        drv(1'b1, 4'h3, 1'b0);
        for (int i = 0; i < 40; i++) drv(1'b1, (i % 2) ? 4'hD : 4'h5, 1'b0);
        idle(10);
        checks++; if (mon_data.size() - base !== 0) begin errors++; $display("FAIL badpre_n got %0d exp 0", mon_data.size() - base); end
        build_frame(OWN, 64, f);
        base = mon_data.size();
        send_frame(f, 1'b0, 0, 0); idle(20);
        analyze(base, f);
        checks++; if (a_n !== 60) begin errors++; $display("FAIL afterpre_n got %0d exp 60", a_n); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL afterpre_err got %b exp 0", a_err); end
        checks++; if (a_bad !== 0) begin errors++; $display("FAIL afterpre_data got %0d bad exp 0", a_bad); end
    endtask

    task automatic test_reset_mid();
        bq_t f; int base;
        build_frame(OWN, 64, f);
        base = mon_data.size();
        rst_snap = '1;
        send_frame(f, 1'b0, 0, 30); idle(20);
        analyze(base, f);
        checks++; if (rst_snap !== 12'h000) begin errors++; $display("FAIL midrst_outs got %h exp 000", rst_snap); end
        checks++; if (a_eop_n !== 0) begin errors++; $display("FAIL midrst_eop got %0d exp 0", a_eop_n); end
        checks++; if (mon_data.size() - rel_base !== 0) begin errors++; $display("FAIL midrst_after got %0d exp 0", mon_data.size() - rel_base); end
    endtask

    task automatic test_back_to_back();
        bq_t f1; bq_t f2; bq_t exp; int base;
        build_frame(BCAST, 70, f1);
        build_frame(OWN, 64, f2);
        exp = {f1[0:65], f2[0:59]};
        base = mon_data.size();
        send_frame(f1, 1'b0, 0, 0); idle(23);
        send_frame(f2, 1'b0, 0, 0); idle(20);
        analyze(base, exp);
        checks++; if (a_n !== 126) begin errors++; $display("FAIL b2b_n got %0d exp 126", a_n); end
        checks++; if (a_sop_n !== 2) begin errors++; $display("FAIL b2b_sop_n got %0d exp 2", a_sop_n); end
        checks++; if (a_eop_n !== 2) begin errors++; $display("FAIL b2b_eop_n got %0d exp 2", a_eop_n); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", a_err); end
        checks++; if (a_bad !== 0) begin errors++; $display("FAIL b2b_data got %0d bad exp 0", a_bad); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rel_base = 0;
        test_reset();
        test_good();
        test_bitflip();
        test_filter();
        test_rx_errors();
        test_lengths();
        test_bad_preamble();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
